imem_loader: RTL and testbench

Sequential program loader that writes the instruction memory which the fetch path later reads. It receives a byte stream over a valid/ready handshake and assembles the bytes MSB-first into 32-bit instruction words. Each word is written to consecutive word addresses inside one 128-byte memory window, and a trailing XOR checksum byte is verified. While loading, the block holds the CPU off so the fetch path never reads a partially loaded program.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StWrite   = 3'd2,
        StCheck   = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam int unsigned BytesPerWord   = 4;
    localparam int unsigned WordOffsetBits = 5;

    // A load request is legal only for 1..max_words words.
    function automatic logic num_words_ok(input logic [5:0] n, input int unsigned max_words);
        return (n != 6'd0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words and flags the byte that completes each word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] next_word,
    output logic        word_complete
);

    logic [1:0]  byte_idx_q;
    logic [31:0] shift_q;

    // Word as it will stand once the byte on byte_data is shifted in.
    assign next_word     = {shift_q[23:0], byte_data};
    assign word_complete = byte_valid && (byte_idx_q == 2'(BytesPerWord - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
        end else if (clear) begin
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
        end else if (byte_valid) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            shift_q    <= next_word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program into the instruction memory window, holding the CPU meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [24:0] BASE_ADDRESS = 25'd0,
    parameter int unsigned MAX_WORDS    = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  num_words,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        chk_err,
    output logic [5:0]  words_written
);

    state_e                      state_q, state_d;
    logic [5:0]                  num_words_q;
    logic [WordOffsetBits-1:0]   word_idx_q;
    logic [7:0]                  checksum_q;
    logic [31:0]                 mem_addr_q, mem_wdata_q;
    logic [5:0]                  words_written_q;
    logic                        chk_err_q;

    logic        accept;
    logic        xfer;
    logic        byte_valid;
    logic        last_word;
    logic [31:0] next_word;
    logic        word_complete;

    assign xfer       = rx_valid && rx_ready;
    assign byte_valid = xfer && (state_q == StCollect);
    assign last_word  = (word_idx_q == WordOffsetBits'(num_words_q - 6'd1));

    word_assembler u_word_assembler (
        .clk           (clk),
        .rst_n         (reset_n),
        .clear         (accept),
        .byte_valid    (byte_valid),
        .byte_data     (rx_data),
        .next_word     (next_word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && num_words_ok(num_words, MAX_WORDS)) begin
                    accept  = 1'b1;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                rx_ready = 1'b1;
                if (word_complete) state_d = StWrite;
            end
            StWrite:  state_d = last_word ? StCheck : StCollect;
            StCheck: begin
                rx_ready = 1'b1;
                if (xfer) state_d = StDone;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            num_words_q     <= 6'd0;
            word_idx_q      <= '0;
            checksum_q      <= 8'd0;
            mem_addr_q      <= 32'd0;
            mem_wdata_q     <= 32'd0;
            words_written_q <= 6'd0;
            chk_err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                num_words_q     <= num_words;
                word_idx_q      <= '0;
                checksum_q      <= 8'd0;
                words_written_q <= 6'd0;
                chk_err_q       <= 1'b0;
            end
            if (byte_valid) checksum_q <= checksum_q ^ rx_data;
            // Capture address and data as the word completes so both are stable during WRITE.
            if (word_complete) begin
                mem_wdata_q <= next_word;
                mem_addr_q  <= {BASE_ADDRESS, word_idx_q, 2'b00};
            end
            if (state_q == StWrite) begin
                words_written_q <= words_written_q + 6'd1;
                if (!last_word) word_idx_q <= word_idx_q + 1'b1;
            end
            if ((state_q == StCheck) && xfer) chk_err_q <= (rx_data != checksum_q);
        end
    end

    assign mem_we        = (state_q == StWrite);
    assign done          = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign cpu_hold      = busy;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_written_q;
    assign chk_err       = chk_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes/completions queued, monitor compares.
module tb_imem_loader;

    localparam logic [24:0] Base = 25'd0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  num_words = 6'd0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_hold, busy, done, chk_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [5:0]  words_written;

    imem_loader #(.BASE_ADDRESS(Base), .MAX_WORDS(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_words     (num_words),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .chk_err       (chk_err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic err; logic [5:0] cnt; } dn_t;

    wr_t         exp_wr[$];
    dn_t         exp_dn[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          we_count = 0;
    int          done_count = 0;
    logic [31:0] last_addr = 32'd0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares every write strobe and completion pulse against the queues.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_t w;
            we_count++;
            last_addr = mem_addr;
            check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("mem_addr", mem_addr, w.addr);
                check("mem_wdata", mem_wdata, w.data);
            end
        end
        if (done) begin
            dn_t d;
            done_count++;
            done_cyc = cyc;
            check("done_expected", 32'(exp_dn.size() != 0), 32'd1);
            if (exp_dn.size() != 0) begin
                d = exp_dn.pop_front();
                check("chk_err_at_done", 32'(chk_err), 32'(d.err));
                check("words_written_at_done", 32'(words_written), 32'(d.cnt));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int budget = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (!rx_ready && budget < 50);
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (gap_mode == 1) begin
            @(posedge clk); #1;
        end else if (gap_mode == 2 && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_start(input logic [5:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_words = n;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] data[$], input int w);
        return (32'(data[4*w]) << 24) | (32'(data[4*w+1]) << 16) |
               (32'(data[4*w+2]) << 8) | 32'(data[4*w+3]);
    endfunction

    function automatic logic [31:0] addr_of(input int w);
        return 32'(Base) * 32'd128 + 32'(w) * 32'd4;
    endfunction

    task automatic wait_done(input int d0);
        int budget = 0;
        while (done_count == d0 && budget < 40) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("done_seen", 32'(done_count), 32'(d0 + 1));
    endtask

    task automatic run_load(input int n, input logic [7:0] data[$], input logic bad,
                            input int gap);
        logic [7:0] cs = 8'd0;
        wr_t        w;
        dn_t        d;
        int         d0;
        foreach (data[i]) cs ^= data[i];
        for (int i = 0; i < n; i++) begin
            w.addr = addr_of(i);
            w.data = word_of(data, i);
            exp_wr.push_back(w);
        end
        d.err = bad;
        d.cnt = 6'(n);
        exp_dn.push_back(d);
        d0 = done_count;
        issue_start(6'(n));
        check("chk_err_cleared_on_start", 32'(chk_err), 32'd0);
        foreach (data[i]) send_byte(data[i], gap);
        send_byte(bad ? (cs ^ 8'h01) : cs, gap);
        wait_done(d0);
    endtask

    task automatic rand_data(input int n, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_chk_err"}, 32'(chk_err), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_words_written"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        logic [7:0] basic[$];
        logic [7:0] q[$];
        int         w0;
        int         busy_seen;
        int         d0;
        wr_t        w;
        dn_t        d;
        basic = {8'h8C, 8'h03, 8'h00, 8'h08, 8'h20, 8'h63, 8'h00, 8'h06};

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic load, then the same stream with a corrupted checksum.
        run_load(2, basic, 1'b0, 0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd0);
        check("basic_words_written", 32'(words_written), 32'd2);
        run_load(2, basic, 1'b1, 0);
        repeat (5) @(negedge clk);
        check("chk_err_sticky", 32'(chk_err), 32'd1);

        // Valid toggling every cycle.
        run_load(2, basic, 1'b0, 1);

        // Full window without gaps: minimum latency and last address.
        rand_data(32, q);
        run_load(32, q, 1'b0, 0);
        check("latency_32", 32'(done_cyc - start_cyc + 1), 32'd163);
        check("last_addr_32", last_addr, addr_of(31));

        // Out-of-range requests are ignored.
        for (int k = 0; k < 2; k++) begin
            w0 = we_count;
            busy_seen = 0;
            issue_start(k == 0 ? 6'd0 : 6'd33);
            repeat (10) begin
                @(negedge clk);
                if (busy) busy_seen++;
            end
            check("invalid_start_busy", 32'(busy_seen), 32'd0);
            check("invalid_start_writes", 32'(we_count - w0), 32'd0);
        end

        // Reset after 6 bytes of a 2-word load.
        rand_data(2, q);
        w.addr = addr_of(0);
        w.data = word_of(q, 0);
        exp_wr.push_back(w);
        w0 = we_count;
        issue_start(6'd2);
        for (int i = 0; i < 6; i++) send_byte(q[i], 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midload_reset");
        check("midload_writes", 32'(we_count - w0), 32'd1);
        exp_wr.delete();
        exp_dn.delete();
        @(negedge clk);
        reset_n = 1'b1;
        rand_data(2, q);
        run_load(2, q, 1'b0, 0);

        // Start pulsed mid-collect must not disturb the running load.
        rand_data(2, q);
        for (int i = 0; i < 2; i++) begin
            w.addr = addr_of(i);
            w.data = word_of(q, i);
            exp_wr.push_back(w);
        end
        d.err = 1'b0;
        d.cnt = 6'd2;
        exp_dn.push_back(d);
        d0 = done_count;
        issue_start(6'd2);
        send_byte(q[0], 0);
        send_byte(q[1], 0);
        issue_start(6'd5);
        check("busy_start_cpu_hold", 32'(cpu_hold), 32'd1);
        for (int i = 2; i < 8; i++) send_byte(q[i], 0);
        send_byte(q[0] ^ q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[5] ^ q[6] ^ q[7], 0);
        wait_done(d0);

        // Random loads with random gaps and occasional bad checksums.
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 32);
            rand_data(n, q);
            run_load(n, q, 1'($urandom_range(0, 1)), 2);
        end

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(exp_wr.size() + exp_dn.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
